// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: read-side memory dump initiator.
//
// On START (sampled in IDLE) walks word addresses 0..DEPTH-1, issues one
// single-cycle read per word, and serializes each 16-bit word as two bytes
// (high byte first) on a valid/ready byte stream feeding a UART transmitter.
// The block never writes memory.
//
// Optional build macro: MEM_DUMP_HEADER_EN
//   When defined, every dump is prefixed by a two-byte header:
//   0xA5 followed by DEPTH[7:0].
//
// Ports:
//   CLK       system clock, rising edge
//   RESET     asynchronous, active-high reset
//   START     dump request, only honoured in IDLE
//   BUSY      high in every state except IDLE
//   DONE      one-cycle pulse after the last byte is accepted
//   MEM_RD    read strobe, high only during the READ cycle
//   MEM_WR    write strobe, tied low
//   MEM_ADDR  word address (the dump address counter)
//   MEM_DATA  read data, registered by memory on the falling edge
//   TX_DATA   byte to transmitter
//   TX_VALID  TX_DATA valid
//   TX_READY  transmitter accepts a byte when TX_VALID && TX_READY
module mem_dump_ctrl #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef MEM_DUMP_HEADER_EN
  localparam logic [7:0] HDR_MAGIC_BYTE = 8'hA5;
  localparam logic [7:0] HDR_LEN_BYTE   = 8'(DEPTH);
`endif

  typedef enum logic [2:0] {
    IDLE,
    READ,
    TX_HI,
    TX_LO,
    FINISH
`ifdef MEM_DUMP_HEADER_EN
    , HDR_MAGIC,
    HDR_LEN
`endif
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] word, word_n;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      addr  <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      word  <= word_n;
    end
  end

  // Next state. TX_VALID is 1 in every byte-sending state, so an accept
  // there reduces to TX_READY alone.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    word_n  = word;
    case (state)
      IDLE: begin
        if (START) begin
          addr_n  = '0;
`ifdef MEM_DUMP_HEADER_EN
          state_n = HDR_MAGIC;
`else
          state_n = READ;
`endif
        end
      end
`ifdef MEM_DUMP_HEADER_EN
      HDR_MAGIC: if (TX_READY) state_n = HDR_LEN;
      HDR_LEN:   if (TX_READY) state_n = READ;
`endif
      READ: begin
        // Memory drops MEM_DATA to 0 once MEM_RD falls, so capture it here.
        word_n  = MEM_DATA;
        state_n = TX_HI;
      end
      TX_HI: if (TX_READY) state_n = TX_LO;
      TX_LO: begin
        if (TX_READY) begin
          if (addr == LAST_ADDR) begin
            state_n = FINISH;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = READ;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state/word only.
  always_comb begin
    BUSY     = (state != IDLE);
    DONE     = (state == FINISH);
    MEM_RD   = (state == READ);
    MEM_WR   = 1'b0;
    MEM_ADDR = addr;
    TX_VALID = 1'b0;
    TX_DATA  = 8'h00;
    case (state)
`ifdef MEM_DUMP_HEADER_EN
      HDR_MAGIC: begin TX_VALID = 1'b1; TX_DATA = HDR_MAGIC_BYTE; end
      HDR_LEN:   begin TX_VALID = 1'b1; TX_DATA = HDR_LEN_BYTE;   end
`endif
      TX_HI:   begin TX_VALID = 1'b1; TX_DATA = word[15:8]; end
      TX_LO:   begin TX_VALID = 1'b1; TX_DATA = word[7:0];  end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Read-side initiator for the BIP data memory. On a START request it walks data memory addresses 0 to DEPTH-1 and issues one read per word. It serializes each 16-bit word into two bytes on a valid/ready byte stream, which feeds the UART transmitter for post-run memory inspection. The block never writes memory.

## Interface
- DEPTH, 10: number of words dumped, from address 0 to DEPTH-1; range 1..255.
- ADDR_W, 11: memory address width.
- DATA_W, 16: memory word width; fixed at 16 (two bytes per word).
- CLK  in  1  system clock; all block state updates on the rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- START  in  1  dump request; sampled only in IDLE.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last byte is accepted.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe; constant 0.
- MEM_ADDR  out  ADDR_W  memory word address.
- MEM_DATA  in  DATA_W  memory read data; the memory registers it on the falling edge while MEM_RD=1 and MEM_WR=0, and drives 0 otherwise.
- TX_DATA  out  8  byte to transmitter.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  transmitter accepts a byte at any rising edge where TX_VALID and TX_READY are both 1.

## Operation
- States: IDLE, HDR_MAGIC, HDR_LEN (header states exist only with the macro), READ, TX_HI, TX_LO, FINISH.
- IDLE: START=1 at a rising edge clears the address counter to 0 and moves to READ, or to HDR_MAGIC when the header is enabled. START=0 stays in IDLE.
- READ: lasts exactly one cycle. MEM_RD=1 and MEM_ADDR=addr. On the rising edge ending READ, the word register loads MEM_DATA and the state moves to TX_HI.
- TX_HI: TX_VALID=1, TX_DATA=word[15:8]. Holds until the byte is accepted, then moves to TX_LO.
- TX_LO: TX_VALID=1, TX_DATA=word[7:0]. On accept:
  - if addr==DEPTH-1, move to FINISH;
  - otherwise addr increments by 1 and the state moves to READ.
- FINISH: DONE=1 for exactly one cycle, then IDLE. BUSY=1 in FINISH.
- MEM_RD is 1 only in READ. MEM_ADDR holds the address counter in all states.
- START while BUSY=1 is ignored; it is neither queued nor a restart.
- TX_DATA is stable while TX_VALID=1 and not yet accepted.
- The address counter is ADDR_W bits, compared against DEPTH-1. It never wraps, because DEPTH-1 fits in ADDR_W.

## Timing
- Reset values: BUSY=0, DONE=0, MEM_RD=0, MEM_WR=0, MEM_ADDR=0, TX_DATA=0, TX_VALID=0; state IDLE; word register 0.
- All outputs are decoded from registered state only (Moore); no combinational path from TX_READY or START to any output.
- Start latency: START sampled at rising edge k gives MEM_RD=1 in cycle k+1 and TX_VALID=1 in cycle k+2.
- Memory read latency: MEM_DATA is valid at the end of the single READ cycle, via the falling-edge register. It must be captured there, because the memory returns 0 once MEM_RD drops.
- Throughput with TX_READY held at 1: 3 cycles per word. A full dump is 3*DEPTH+1 cycles from the first READ through FINISH, plus 2 cycles with the header.
- TX_READY low stalls TX_HI or TX_LO indefinitely. Memory is not re-read during a stall.
- Reset asserted mid-dump: immediate return to IDLE with all outputs at their reset values. The partial word is not completed and DONE does not pulse.
- START and TX_READY in the same IDLE cycle: START wins; TX_READY is irrelevant outside the TX states.

## Configuration
- MEM_DUMP_HEADER_EN defined:
  - IDLE→HDR_MAGIC on START.
  - HDR_MAGIC sends byte 0xA5 and HDR_LEN sends byte DEPTH[7:0], each with the same valid/ready rule.
  - HDR_LEN on accept moves to READ.
  - Total bytes per dump: 2*DEPTH+2.
- Not defined: the header states and their logic are absent, IDLE→READ directly, and total bytes per dump is 2*DEPTH.

## Test plan
- Reset, then memory preloaded with words 0x1234, 0x0001 .. 0x0009, TX_READY=1, START pulse → byte stream 0x12,0x34,0x00,0x01,…,0x00,0x09. DONE pulses once at cycle 3*10+1 after the first READ, then BUSY=0.
- TX_READY toggling 1,0,0,1 pseudo-randomly → identical byte sequence. TX_DATA is stable during every stall and MEM_RD pulses exactly 10 times.
- START pulsed again at mid-dump (address 4) → no restart and no extra MEM_RD. A single DONE occurs at the normal end.
- RESET asserted while in TX_LO at address 6 → TX_VALID, BUSY and MEM_RD are 0 immediately and no DONE. A subsequent START dumps again from address 0.
- MEM_WR checked over all scenarios → always 0. Memory contents are unchanged after the dump.
- With MEM_DUMP_HEADER_EN, DEPTH=10 → the first two bytes are 0xA5 and 0x0A, followed by the 20 data bytes, 22 bytes in total.
